tcam_rule_programmer: RTL and testbench
=======================================

Name: tcam_rule_programmer

Overview:
- Host-side write engine for the 64-rule × 28-bit SRAM-based TCAM wrapper.
- Buffers up to 8 ternary rules, one byte lane (rule group), then sweeps all 4 blocks × 128 rows.
- For each row it issues one byte-masked write carrying the 8 match bits.
- Converts rule-oriented programming (key + care mask) into the per-block, per-subkey row bitmaps the TCAM memory stores.

Parameters:
- KEY_W, 28, full search key width
- SUB_W, 7, subkey width per block (rows = 2**SUB_W = 128)
- N_BLK, 4, number of TCAM blocks (KEY_W = N_BLK*SUB_W)
- DATA_W, 32, memory write data width (4 byte lanes)

Ports:
- in_clk  input  1  clock
- in_rst  input  1  reset
- in_ld_valid  input  1  load a rule into buffer slot
- out_ld_ready  output  1  buffer accepts load
- in_ld_slot  input  3  buffer slot (rule index within group)
- in_ld_key  input  28  rule key bits
- in_ld_care  input  28  care mask (1 = compare, 0 = don't care)
- in_ld_en  input  1  rule enable (0 = rule never matches)
- in_cmt_valid  input  1  start sweep for a group
- out_cmt_ready  output  1  engine idle
- in_cmt_group  input  3  rule group g (rules 8g..8g+7)
- in_mem_gnt  input  1  memory port granted to this engine this cycle
- out_csb  output  1  memory chip select, active low
- out_web  output  1  memory write enable, active low
- out_wmask  output  4  byte write mask
- out_addr  output  28  memory address
- out_wdata  output  32  memory write data
- out_busy  output  1  sweep in progress
- out_done  output  1  one-cycle pulse at sweep completion

Behaviour:
- Clock is in_clk; reset is in_rst, synchronous, active-high.
- Reset values:
  - out_csb=1, out_web=1, out_wmask=0, out_addr=0, out_wdata=0
  - out_busy=0, out_done=0; out_ld_ready=1, out_cmt_ready=1
  - all 8 slot enable bits cleared
- Buffer: 8 slots of {key[27:0], care[27:0], en}.
  - A load occurs when in_ld_valid && out_ld_ready; it overwrites the slot.
  - out_ld_ready = (state==IDLE). The buffer is frozen during a sweep.
- FSM states: IDLE, SWEEP, DONE.
  - IDLE: on in_cmt_valid (out_cmt_ready=1), latch group g, clear blk=0 and row=0, go to SWEEP.
  - Same-cycle load and commit: the load is applied first, and the sweep uses the updated slot.
  - SWEEP: each cycle with in_mem_gnt=1, drive one registered write, then advance row. On row wrap 127→0, advance blk. After blk=3/row=127 is issued, go to DONE.
  - SWEEP with in_mem_gnt=0: out_csb=1, counters hold, no write issued.
  - DONE: out_done=1 for one cycle, out_csb=1, return to IDLE.
  - out_busy=1 in SWEEP and DONE. out_cmt_ready=0 outside IDLE; commits there are ignored, not queued.
- Write encoding, for cycle (blk b, row r, group g):
  - out_csb=0, out_web=0
  - out_addr = {18'b0, b[1:0], g[2], r[6:0]}
  - out_wmask = 4'b0001 << g[1:0]
  - out_wdata byte lane g[1:0] bit i = en[i] && (((r ^ key_i[7b+6:7b]) & care_i[7b+6:7b]) == 0); all other lanes 0.
- Latency and throughput:
  - Commit accepted in cycle N → first write driven in cycle N+1.
  - With continuous grant: 512 write cycles, out_done in cycle N+513, out_cmt_ready=1 in cycle N+514.
- Boundaries:
  - care=0 with en=1 matches every row; en=0 writes 0 on every row.
  - Slots not loaded since reset read as en=0.
- Reset mid-sweep: abort immediately, out_csb=1 next cycle, no out_done. Memory contents of the group are undefined until re-committed.

Decomposition:
- Package tcam_prog_pkg:
  - KEY_W, SUB_W, N_BLK, DATA_W, N_SLOT=8
  - typedef rule_t {key, care, en}
  - enum state_e {IDLE, SWEEP, DONE}
  - function for address packing
- One sub-module, tcam_row_match: combinational 8-slot subkey compare producing the 8-bit lane byte for (blk, row).

Test Plan:
- Reset, then load slot0 key=0x0000000 care=0xFFFFFFF en=1, commit g=0 → exactly 512 writes:
  - wdata=0x00000001 only at addr 0x000, 0x080? No: only at addr 0x000, 0x100, 0x200, 0x300 (row 0 of each block).
  - All other writes wdata=0, wmask=0001, out_done in cycle N+513.
- Slot3 key=0x0000005 care=0x000007F en=1, commit g=5 → every write has wmask=0010:
  - addr = {b,1,r}; block0 row5 (addr 0x085) wdata=0x00000800.
  - Blocks 1–3, all rows: wdata=0x00000800 (don't care).
- Slot7 en=0, care=0 → bit 7 of the lane is 0 on all 512 writes. Slot0 care=0 en=1 → bit 0 is 1 on all 512 writes.
- Toggle in_mem_gnt 1/0 every cycle during the sweep:
  - 512 writes in 1023 cycles, no address skipped or repeated.
  - out_csb=1 on every non-grant cycle.
- Commit and load while busy → out_ld_ready=0, out_cmt_ready=0, buffer and group unchanged, second sweep not started.
- Assert in_rst at write 200 → next cycle out_csb=1, out_busy=0, no out_done. A new commit after reset writes lane bits 0 (slots cleared).

Source files
------------

// File: rtl/tcam_prog_pkg.sv
// -----------------------------------------------------------------------------
// tcam_prog_pkg
// Shared types and constants for the TCAM rule programmer.
//   KEY_W  : full search key width (N_BLK * SUB_W)
//   SUB_W  : subkey width per block; each block has 2**SUB_W rows
//   N_BLK  : number of TCAM blocks
//   DATA_W : memory write data width (DATA_W/8 byte lanes)
//   N_SLOT : rules buffered per group (one byte lane, one bit per rule)
// -----------------------------------------------------------------------------
package tcam_prog_pkg;

   localparam int KEY_W  = 28;
   localparam int SUB_W  = 7;
   localparam int N_BLK  = 4;
   localparam int DATA_W = 32;
   localparam int N_SLOT = 8;

   localparam int N_LANE = DATA_W / 8;
   localparam int LANE_W = 2;
   localparam int BLK_W  = 2;
   localparam int SLOT_W = 3;
   localparam int GRP_W  = 3;

   typedef struct packed {
      logic [KEY_W-1:0] key;
      logic [KEY_W-1:0] care;
      logic             en;
   } rule_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWEEP = 2'd1,
      DONE  = 2'd2
   } state_e;

   // Row address inside the memory: {block, group-half, row}. The low two
   // group bits select the byte lane, so only the top group bit lands here.
   function automatic logic [KEY_W-1:0] pack_addr(input logic [BLK_W-1:0] blk,
                                                  input logic [GRP_W-1:0] grp,
                                                  input logic [SUB_W-1:0] row);
      pack_addr = {{(KEY_W-BLK_W-1-SUB_W){1'b0}}, blk, grp[GRP_W-1], row};
   endfunction

endpackage

// File: rtl/tcam_row_match.sv
// -----------------------------------------------------------------------------
// tcam_row_match
// Combinational compare of one (block, row) against all buffered rules.
// Bit i of the result is set when rule i is enabled and the row value equals
// the rule's subkey for this block on every cared bit.
//   in_rules  : buffered rules, one per slot
//   in_blk    : block index selecting the subkey slice of each rule
//   in_row    : row index (the subkey value this memory row represents)
//   out_match : one match bit per slot, becomes the lane byte
// -----------------------------------------------------------------------------
module tcam_row_match
   import tcam_prog_pkg::*;
(
   input  rule_t [N_SLOT-1:0] in_rules,
   input  logic  [BLK_W-1:0]  in_blk,
   input  logic  [SUB_W-1:0]  in_row,
   output logic  [N_SLOT-1:0] out_match
);

   always_comb begin
      out_match = '0;
      for (int i = 0; i < N_SLOT; i++) begin
         out_match[i] = in_rules[i].en &&
            (((in_row ^ in_rules[i].key[SUB_W*in_blk +: SUB_W]) &
              in_rules[i].care[SUB_W*in_blk +: SUB_W]) == '0);
      end
   end

endmodule

// File: rtl/tcam_rule_programmer.sv
// -----------------------------------------------------------------------------
// tcam_rule_programmer
// Host-side write engine for the SRAM-based TCAM. Rules (key + care mask +
// enable) are loaded into an 8-slot buffer; a commit for group g then sweeps
// every block and row, issuing one byte-masked write per row that carries the
// 8 match bits of the group's rules in byte lane g[1:0].
//   in_clk / in_rst          : clock, synchronous active-high reset
//   in_ld_*  / out_ld_ready  : rule load into buffer slot in_ld_slot
//   in_cmt_* / out_cmt_ready : start a sweep for rule group in_cmt_group
//   in_mem_gnt               : memory port granted this cycle
//   out_csb/web/wmask/addr/wdata : memory write port (active-low strobes)
//   out_busy / out_done      : sweep in progress / completion pulse
// -----------------------------------------------------------------------------
module tcam_rule_programmer
   import tcam_prog_pkg::*;
(
   input  logic              in_clk,
   input  logic              in_rst,
   input  logic              in_ld_valid,
   output logic              out_ld_ready,
   input  logic [SLOT_W-1:0] in_ld_slot,
   input  logic [KEY_W-1:0]  in_ld_key,
   input  logic [KEY_W-1:0]  in_ld_care,
   input  logic              in_ld_en,
   input  logic              in_cmt_valid,
   output logic              out_cmt_ready,
   input  logic [GRP_W-1:0]  in_cmt_group,
   input  logic              in_mem_gnt,
   output logic              out_csb,
   output logic              out_web,
   output logic [N_LANE-1:0] out_wmask,
   output logic [KEY_W-1:0]  out_addr,
   output logic [DATA_W-1:0] out_wdata,
   output logic              out_busy,
   output logic              out_done
);

   state_e             r_state;
   state_e             w_state_nxt;
   logic [KEY_W-1:0]   r_key  [N_SLOT];
   logic [KEY_W-1:0]   r_care [N_SLOT];
   logic [N_SLOT-1:0]  r_en;
   logic [GRP_W-1:0]   r_grp;
   logic [BLK_W-1:0]   r_blk;
   logic [SUB_W-1:0]   r_row;

   rule_t [N_SLOT-1:0] w_rules;
   logic [N_SLOT-1:0]  w_match;
   logic               w_idle;
   logic               w_ld;
   logic               w_cmt;
   logic               w_wr;
   logic               w_last;

   assign w_idle = (r_state == IDLE);
   assign w_ld   = in_ld_valid  && w_idle;
   assign w_cmt  = in_cmt_valid && w_idle;
   assign w_wr   = (r_state == SWEEP) && in_mem_gnt;
   assign w_last = (r_blk == BLK_W'(N_BLK-1)) && (r_row == '1);

   // Key/care storage carries no reset: a slot is only meaningful once its
   // enable bit is set, and the enable bits are cleared by reset.
   always_ff @(posedge in_clk) begin
      if (w_ld) begin
         r_key[in_ld_slot]  <= in_ld_key;
         r_care[in_ld_slot] <= in_ld_care;
      end
   end

   always_ff @(posedge in_clk) begin
      if (in_rst) begin
         r_state <= IDLE;
         r_en    <= '0;
         r_grp   <= '0;
         r_blk   <= '0;
         r_row   <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_ld) begin
            r_en[in_ld_slot] <= in_ld_en;
         end
         if (w_cmt) begin
            r_grp <= in_cmt_group;
            r_blk <= '0;
            r_row <= '0;
         end else if (w_wr) begin
            // Row wraps naturally at 2**SUB_W; the block steps on that wrap.
            r_row <= r_row + 1'b1;
            if (r_row == '1) begin
               r_blk <= r_blk + 1'b1;
            end
         end
      end
   end

   always_comb begin
      w_rules = '0;
      for (int i = 0; i < N_SLOT; i++) begin
         w_rules[i].key  = r_key[i];
         w_rules[i].care = r_care[i];
         w_rules[i].en   = r_en[i];
      end
   end

   tcam_row_match u_row_match (
      .in_rules  (w_rules),
      .in_blk    (r_blk),
      .in_row    (r_row),
      .out_match (w_match)
   );

   always_comb begin
      w_state_nxt   = r_state;
      out_ld_ready  = w_idle;
      out_cmt_ready = w_idle;
      out_busy      = !w_idle;
      out_done      = 1'b0;
      out_csb       = 1'b1;
      out_web       = 1'b1;
      out_wmask     = '0;
      out_addr      = '0;
      out_wdata     = '0;

      // The write strobe follows the grant in the same cycle; address and
      // data come straight from the registered counters and buffer.
      if (w_wr) begin
         out_csb   = 1'b0;
         out_web   = 1'b0;
         out_wmask = N_LANE'(1) << r_grp[LANE_W-1:0];
         out_addr  = pack_addr(r_blk, r_grp, r_row);
         out_wdata = {{(DATA_W-N_SLOT){1'b0}}, w_match} << {r_grp[LANE_W-1:0], 3'b000};
      end

      case (r_state)
         IDLE: begin
            if (in_cmt_valid) begin
               w_state_nxt = SWEEP;
            end
         end
         SWEEP: begin
            if (w_wr && w_last) begin
               w_state_nxt = DONE;
            end
         end
         DONE: begin
            out_done    = 1'b1;
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_tcam_rule_programmer.sv
// -----------------------------------------------------------------------------
// tb_tcam_rule_programmer
// Scoreboard bench: each commit pushes its 512 expected writes into a queue,
// and a negedge monitor pops and compares every write the engine issues.
// Hand-computed spot values are checked from the per-sweep write log.
// -----------------------------------------------------------------------------
module tb_tcam_rule_programmer;

   logic        in_clk = 1'b0;
   logic        in_rst;
   logic        in_ld_valid;
   logic        out_ld_ready;
   logic [2:0]  in_ld_slot;
   logic [27:0] in_ld_key;
   logic [27:0] in_ld_care;
   logic        in_ld_en;
   logic        in_cmt_valid;
   logic        out_cmt_ready;
   logic [2:0]  in_cmt_group;
   logic        in_mem_gnt;
   logic        out_csb;
   logic        out_web;
   logic [3:0]  out_wmask;
   logic [27:0] out_addr;
   logic [31:0] out_wdata;
   logic        out_busy;
   logic        out_done;

   tcam_rule_programmer dut (
      .in_clk        (in_clk),
      .in_rst        (in_rst),
      .in_ld_valid   (in_ld_valid),
      .out_ld_ready  (out_ld_ready),
      .in_ld_slot    (in_ld_slot),
      .in_ld_key     (in_ld_key),
      .in_ld_care    (in_ld_care),
      .in_ld_en      (in_ld_en),
      .in_cmt_valid  (in_cmt_valid),
      .out_cmt_ready (out_cmt_ready),
      .in_cmt_group  (in_cmt_group),
      .in_mem_gnt    (in_mem_gnt),
      .out_csb       (out_csb),
      .out_web       (out_web),
      .out_wmask     (out_wmask),
      .out_addr      (out_addr),
      .out_wdata     (out_wdata),
      .out_busy      (out_busy),
      .out_done      (out_done)
   );

   always #5 in_clk = ~in_clk;

   typedef struct {
      int          addr;
      logic [3:0]  mask;
      logic [31:0] data;
   } exp_t;

   exp_t        expq[$];
   logic [31:0] wr_log [int];
   int          n_vec = 0;
   int          n_bad = 0;
   int          wr_cnt = 0;
   int          done_cnt = 0;
   int          cyc = 0;

   logic [27:0] m_key  [8];
   logic [27:0] m_care [8];
   logic        m_en   [8];

   always @(posedge in_clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Expected lane byte straight from the rule definition.
   function automatic logic [7:0] exp_byte(input int b, input int r);
      logic [7:0] v;
      logic [6:0] sk;
      logic [6:0] cm;
      v = 8'h00;
      for (int i = 0; i < 8; i++) begin
         sk = 7'((m_key[i]  >> (7*b)) & 28'h7F);
         cm = 7'((m_care[i] >> (7*b)) & 28'h7F);
         if (m_en[i] && (((7'(r) ^ sk) & cm) == 7'h00)) v[i] = 1'b1;
      end
      return v;
   endfunction

   // Monitor: every issued write must match the head of the scoreboard.
   always @(negedge in_clk) begin
      exp_t e;
      if (out_done === 1'b1) done_cnt++;
      if (out_csb === 1'b0) begin
         wr_cnt++;
         if (expq.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected_write: addr %h wdata %h, expected no write", out_addr, out_wdata);
         end else begin
            e = expq.pop_front();
            chk("web",   32'(out_web),   32'h0);
            chk("addr",  32'(out_addr),  32'(e.addr));
            chk("wmask", 32'(out_wmask), 32'(e.mask));
            chk("wdata", out_wdata,      e.data);
            wr_log[int'(out_addr)] = out_wdata;
         end
      end
   end

   task automatic load(input int s, input logic [27:0] k, input logic [27:0] c, input logic e);
      @(posedge in_clk); #1;
      in_ld_valid = 1'b1;
      in_ld_slot  = 3'(s);
      in_ld_key   = k;
      in_ld_care  = c;
      in_ld_en    = e;
      @(negedge in_clk);
      chk("ld_ready_idle", 32'(out_ld_ready), 32'h1);
      @(posedge in_clk); #1;
      in_ld_valid = 1'b0;
      m_key[s]  = k;
      m_care[s] = c;
      m_en[s]   = e;
   endtask

   task automatic spot(input string nm, input int a, input logic [31:0] exp);
      if (wr_log.exists(a)) chk(nm, wr_log[a], exp);
      else begin
         n_vec++;
         n_bad++;
         $display("FAIL %s: addr %h never written, expected %h", nm, a, exp);
      end
   endtask

   // Commit group g and follow the sweep. toggle: grant alternates 1/0.
   // poke: load+commit attempt while busy. abort_at>0: reset after that many writes.
   task automatic run_sweep(input logic [2:0] g, input bit toggle, input bit poke, input int abort_at);
      int  n0;
      int  done_at;
      int  d0;
      bit  seen;
      exp_t e;
      wr_log.delete();
      for (int b = 0; b < 4; b++) begin
         for (int r = 0; r < 128; r++) begin
            e.addr = (b << 8) | (int'(g[2]) << 7) | r;
            e.mask = 4'b0001 << g[1:0];
            e.data = {24'h0, exp_byte(b, r)} << (8 * int'(g[1:0]));
            expq.push_back(e);
         end
      end
      @(posedge in_clk); #1;
      in_cmt_valid = 1'b1;
      in_cmt_group = g;
      in_mem_gnt   = toggle ? 1'b0 : 1'b1;
      n0      = cyc;
      wr_cnt  = 0;
      d0      = done_cnt;
      seen    = 1'b0;
      done_at = 0;
      for (int k = 1; k <= 1100 && !seen; k++) begin
         @(posedge in_clk); #1;
         in_cmt_valid = 1'b0;
         in_ld_valid  = 1'b0;
         if (toggle) in_mem_gnt = ~in_mem_gnt;
         if (poke && k == 10) begin
            in_ld_valid  = 1'b1;
            in_ld_slot   = 3'd3;
            in_ld_key    = 28'hAAAAAAA;
            in_ld_care   = 28'h0000000;
            in_ld_en     = 1'b0;
            in_cmt_valid = 1'b1;
            in_cmt_group = 3'd1;
         end
         @(negedge in_clk);
         if (k == 1) chk("busy_in_sweep", 32'(out_busy), 32'h1);
         if (poke && k == 10) begin
            chk("ld_ready_busy",  32'(out_ld_ready),  32'h0);
            chk("cmt_ready_busy", 32'(out_cmt_ready), 32'h0);
         end
         if (toggle && !in_mem_gnt) chk("csb_no_grant", 32'(out_csb), 32'h1);
         if (abort_at > 0 && wr_cnt >= abort_at) begin
            @(posedge in_clk); #1;
            in_rst = 1'b1;
            @(posedge in_clk); #1;
            in_rst = 1'b0;
            @(negedge in_clk);
            chk("csb_after_rst",  32'(out_csb),  32'h1);
            chk("busy_after_rst", 32'(out_busy), 32'h0);
            repeat (3) @(negedge in_clk);
            chk("no_done_on_abort", 32'(done_cnt), 32'(d0));
            chk("idle_after_rst",   32'(out_cmt_ready), 32'h1);
            expq.delete();
            for (int i = 0; i < 8; i++) m_en[i] = 1'b0;
            return;
         end
         if (out_done === 1'b1) begin
            seen    = 1'b1;
            done_at = cyc;
         end
      end
      in_ld_valid = 1'b0;
      if (!seen) begin
         n_vec++;
         n_bad++;
         $display("FAIL done_timeout: no out_done within 1100 cycles, expected one");
      end else begin
         chk("done_latency", 32'(done_at - n0), toggle ? 32'd1024 : 32'd513);
      end
      chk("write_count",    32'(wr_cnt),      32'd512);
      chk("scoreboard_empty", 32'(expq.size()), 32'd0);
      @(posedge in_clk); #1;
      @(negedge in_clk);
      chk("cmt_ready_after", 32'(out_cmt_ready), 32'h1);
      chk("done_pulse_width", 32'(out_done),     32'h0);
      if (poke) begin
         repeat (5) @(negedge in_clk);
         chk("no_second_sweep", 32'(out_busy), 32'h0);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      in_rst       = 1'b1;
      in_ld_valid  = 1'b0;
      in_ld_slot   = '0;
      in_ld_key    = '0;
      in_ld_care   = '0;
      in_ld_en     = 1'b0;
      in_cmt_valid = 1'b0;
      in_cmt_group = '0;
      in_mem_gnt   = 1'b0;
      for (int i = 0; i < 8; i++) begin
         m_key[i]  = '0;
         m_care[i] = '0;
         m_en[i]   = 1'b0;
      end
      repeat (3) @(posedge in_clk);
      #1 in_rst = 1'b0;
      @(negedge in_clk);
      chk("rst_csb",       32'(out_csb),       32'h1);
      chk("rst_web",       32'(out_web),       32'h1);
      chk("rst_wmask",     32'(out_wmask),     32'h0);
      chk("rst_addr",      32'(out_addr),      32'h0);
      chk("rst_wdata",     out_wdata,          32'h0);
      chk("rst_busy",      32'(out_busy),      32'h0);
      chk("rst_done",      32'(out_done),      32'h0);
      chk("rst_ld_ready",  32'(out_ld_ready),  32'h1);
      chk("rst_cmt_ready", 32'(out_cmt_ready), 32'h1);

      // Exact-match rule on key 0: row 0 of every block only.
      load(0, 28'h0000000, 28'hFFFFFFF, 1'b1);
      run_sweep(3'd0, 1'b0, 1'b0, 0);
      spot("t1_b0r0",   32'h000, 32'h00000001);
      spot("t1_b1r0",   32'h100, 32'h00000001);
      spot("t1_b2r0",   32'h200, 32'h00000001);
      spot("t1_b3r0",   32'h300, 32'h00000001);
      spot("t1_b0r1",   32'h001, 32'h00000000);
      spot("t1_b1r127", 32'h17F, 32'h00000000);

      // Block-0-only rule in group 5 (lane 1, upper half); busy poke mid-sweep.
      load(0, 28'h0000000, 28'h0000000, 1'b0);
      load(3, 28'h0000005, 28'h000007F, 1'b1);
      run_sweep(3'd5, 1'b0, 1'b1, 0);
      spot("t2_b0r5",   32'h085, 32'h00000800);
      spot("t2_b0r4",   32'h084, 32'h00000000);
      spot("t2_b1r0",   32'h180, 32'h00000800);
      spot("t2_b3r127", 32'h3FF, 32'h00000800);

      // Disabled don't-care slot 7, all-match slot 0, toggling grant.
      load(7, 28'h0000000, 28'h0000000, 1'b0);
      load(0, 28'h0000000, 28'h0000000, 1'b1);
      run_sweep(3'd2, 1'b1, 1'b0, 0);
      spot("t3_b0r0",   32'h000, 32'h00010000);
      spot("t3_b0r5",   32'h005, 32'h00090000);
      spot("t3_b1r0",   32'h100, 32'h00090000);
      spot("t3_b3r127", 32'h37F, 32'h00090000);

      // Reset at write 200, then re-commit with the cleared buffer.
      run_sweep(3'd4, 1'b0, 1'b0, 200);
      run_sweep(3'd4, 1'b0, 1'b0, 0);
      spot("t4_b0r0",   32'h080, 32'h00000000);
      spot("t4_b3r127", 32'h3FF, 32'h00000000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
